// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request port, fixed-latency response,
// byte/half/word access with sign/zero extension and alignment/range checks.
module dmem_ctrl #(
    parameter int WORD        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int LANES = WORD / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [WORD-1:0] rdata_q;
    logic            err_q;

    logic [WORD-1:0] mem [DEPTH_WORDS];

    logic            accept;
    logic [WORD-1:0] word_idx;
    logic [AW-1:0]   idx;
    logic            access_err;
    logic [WORD-1:0] rd_shifted;
    logic [WORD-1:0] load_data;
    logic [WORD-1:0] wr_shifted;
    logic [LANES-1:0] byte_en;

    assign req_ready = (state != S_WAIT);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;

    assign accept   = req_valid && req_ready;
    assign word_idx = req_addr >> 2;
    assign idx      = word_idx[AW-1:0];

    always_comb begin
        access_err = 1'b0;
        if (req_size == 2'd3)                            access_err = 1'b1;
        if (req_size == 2'd1 && req_addr[0] != 1'b0)     access_err = 1'b1;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00)  access_err = 1'b1;
        if (word_idx >= WORD'(DEPTH_WORDS))              access_err = 1'b1;
    end

    // Once alignment is legal, shifting by addr[1:0] bytes lands any lane at bit 0.
    assign rd_shifted = mem[idx] >> {req_addr[1:0], 3'b000};
    assign wr_shifted = req_wdata << {req_addr[1:0], 3'b000};

    always_comb begin
        load_data = rd_shifted;
        case (req_size)
            2'd0: load_data = req_unsigned ? {{(WORD-8){1'b0}}, rd_shifted[7:0]}
                                           : {{(WORD-8){rd_shifted[7]}}, rd_shifted[7:0]};
            2'd1: load_data = req_unsigned ? {{(WORD-16){1'b0}}, rd_shifted[15:0]}
                                           : {{(WORD-16){rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_data = rd_shifted;
        endcase
    end

    always_comb begin
        byte_en = '0;
        case (req_size)
            2'd0:    byte_en = LANES'(1) << req_addr[1:0];
            2'd1:    byte_en = LANES'(3) << req_addr[1:0];
            2'd2:    byte_en = '1;
            default: byte_en = '0;
        endcase
    end

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (accept && req_write && !access_err) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= wr_shifted[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        rdata_q <= (!req_write && !access_err) ? load_data : '0;
                        err_q   <= access_err;
                        if (LATENCY > 1) begin
                            state <= S_WAIT;
                            cnt   <= CW'((LATENCY > 1) ? LATENCY - 2 : 0);
                        end else begin
                            state <= S_RESP;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-level reference model with a per-cycle compare on a
// LATENCY=2 instance, plus directed literal checks and a LATENCY=1 throughput run.
module tb_dmem_ctrl;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    dmem_ctrl #(.WORD(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    dmem_ctrl #(.WORD(32), .DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err)
    );

    int errors = 0;
    int checks = 0;
    int e = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory as a little-endian byte store, responses as a timed queue.
    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t       q[$];
    logic [7:0] mb [int unsigned];

    function automatic rsp_t model_access(input logic w, input logic [1:0] sz, input logic u,
                                          input logic [31:0] a, input logic [31:0] d);
        rsp_t r;
        int   nb;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        r.due   = 0;
        r.rdata = 32'h0;
        r.err   = (sz == 2'd3) || (a % nb != 0) || ((a / 4) >= DEPTH);
        if (!r.err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mb[a + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(mb[a + i]) << (8 * i));
                if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                r.rdata = v;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        rsp_t r;
        e = e + 1;
        if (rst_n && req_valid && req_ready) begin
            r = model_access(req_write, req_size, req_unsigned, req_addr, req_wdata);
            r.due = e + LAT - 1;
            q.push_back(r);
        end
    end

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
        logic exp_v, exp_ready;
        if (rst_n) begin
            exp_v     = (q.size() > 0) && (q[0].due == e);
            exp_ready = (q.size() == 0) || (q[0].due <= e);
            chk("model_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            chk("model_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
            if (exp_v) begin
                chk("model_rdata", rsp_rdata, q[0].rdata);
                chk("model_err", {31'b0, rsp_err}, {31'b0, q[0].err});
                void'(q.pop_front());
            end else begin
                chk("idle_rdata", rsp_rdata, 32'h0);
                chk("idle_err", {31'b0, rsp_err}, 32'h0);
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, output int acc);
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1 acc = e;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept, expected accept within 20 cycles");
        end
    endtask

    task automatic wait_rsp(input string name, input int acc,
                            input logic [31:0] exp_d, input logic exp_e);
        bit got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                chk({name, "_lat"}, e, acc + LAT - 1);
                chk({name, "_rdata"}, rsp_rdata, exp_d);
                chk({name, "_err"}, {31'b0, rsp_err}, {31'b0, exp_e});
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no rsp_valid, expected one within 10 cycles", name);
        end
    endtask

    task automatic txn(input string name, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e);
        int acc;
        do_req(w, sz, u, a, d, acc);
        if (acc >= 0) wait_rsp(name, acc, exp_d, exp_e);
    endtask

    logic        tw [8];
    logic [31:0] ta [8];
    logic [31:0] td [8];
    logic [31:0] te [8];

    initial begin
        int acc;
        rst_n = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
        b_req_addr = '0; b_req_wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_err", {31'b0, rsp_err}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        txn("sw_10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        txn("lw_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        txn("sw_20", 1, 2'd2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0);
        txn("lb_23", 0, 2'd0, 0, 32'h23, 32'h0, 32'hFFFFFF80, 0);
        txn("lbu_23", 0, 2'd0, 1, 32'h23, 32'h0, 32'h00000080, 0);
        txn("lh_22", 0, 2'd1, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0);
        txn("lhu_20", 0, 2'd1, 1, 32'h20, 32'h0, 32'h00007F01, 0);
        txn("lb_20", 0, 2'd0, 0, 32'h20, 32'h0, 32'h00000001, 0);

        txn("sw_20b", 1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0, 0);
        txn("sb_21", 1, 2'd0, 0, 32'h21, 32'h000000AA, 32'h0, 0);
        txn("lw_20b", 0, 2'd2, 0, 32'h20, 32'h0, 32'h1122AA44, 0);
        txn("sh_22", 1, 2'd1, 0, 32'h22, 32'hFFFF5566, 32'h0, 0);
        txn("lw_20c", 0, 2'd2, 0, 32'h20, 32'h0, 32'h5566AA44, 0);

        txn("sw_00", 1, 2'd2, 0, 32'h00, 32'h01020304, 32'h0, 0);
        txn("lw_02_err", 0, 2'd2, 0, 32'h02, 32'h0, 32'h0, 1);
        txn("sh_03_err", 1, 2'd1, 0, 32'h03, 32'hBEEF, 32'h0, 1);
        txn("lw_00", 0, 2'd2, 0, 32'h00, 32'h0, 32'h01020304, 0);
        txn("lw_range_err", 0, 2'd2, 0, DEPTH * 4, 32'h0, 32'h0, 1);
        txn("size3_ld_err", 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
        txn("size3_st_err", 1, 2'd3, 0, 32'h10, 32'h12345678, 32'h0, 1);
        txn("lw_10_kept", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        txn("sw_last", 1, 2'd2, 0, DEPTH * 4 - 4, 32'h5A5A0001, 32'h0, 0);
        txn("lw_last", 0, 2'd2, 0, DEPTH * 4 - 4, 32'h0, 32'h5A5A0001, 0);

        // Store accepted, then reset while the response is still pending.
        do_req(1, 2'd2, 0, 32'h34, 32'h12345678, acc);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end
        txn("lw_34_kept", 0, 2'd2, 0, 32'h34, 32'h0, 32'h12345678, 0);

        // LATENCY=1 instance: eight requests with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            tw[i] = 1'b1; ta[i] = 32'(4 * i); td[i] = 32'hA000_0000 + 32'(i); te[i] = 32'h0;
            tw[i+4] = 1'b0; ta[i+4] = 32'(4 * i); td[i+4] = 32'h0; te[i+4] = 32'hA000_0000 + 32'(i);
        end
        @(negedge clk);
        chk("l1_ready_idle", {31'b0, b_req_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            b_req_write = tw[i]; b_req_size = 2'd2; b_req_unsigned = 1'b0;
            b_req_addr = ta[i]; b_req_wdata = td[i]; b_req_valid = 1'b1;
            @(negedge clk);
            chk("l1_ready", {31'b0, b_req_ready}, 32'h1);
            chk("l1_rsp_valid", {31'b0, b_rsp_valid}, 32'h1);
            chk("l1_rdata", b_rsp_rdata, te[i]);
            chk("l1_err", {31'b0, b_rsp_err}, 32'h0);
        end
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("l1_rsp_drop", {31'b0, b_rsp_valid}, 32'h0);
        b_req_write = 1'b0; b_req_addr = 32'h100; b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("l1_range_valid", {31'b0, b_rsp_valid}, 32'h1);
        chk("l1_range_err", {31'b0, b_rsp_err}, 32'h1);
        chk("l1_range_rdata", b_rsp_rdata, 32'h0);

        repeat (3) @(negedge clk);
        chk("model_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
